number_mmio_controller: RTL and testbench

//  Sequences the keyboard number-input buffer for the CPU: detects a completed entry (number_valid),

---
 rtl/number_io_pkg.sv | 27 ++
 rtl/bcd_mac_x10.sv | 17 +
 rtl/number_mmio_controller.sv | 168 ++++++++++++++++
 tb/tb_number_mmio_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/number_io_pkg.sv
// Shared definitions for the keyboard number-input MMIO block: register offsets,
// STATUS bit positions, FSM encoding and BCD digit width.
package number_io_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h5000_0000;
    localparam int          BUS_W     = 32;
    localparam int          DIGIT_W   = 4;

    localparam logic [3:0] OFF_VALUE  = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RAW    = 4'h8;
    localparam logic [3:0] OFF_COUNT  = 4'hC;

    localparam int ST_READY   = 0;
    localparam int ST_PENDING = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_ERR     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_CONVERT,
        S_READY,
        S_WAIT_CLR
    } state_t;

endpackage

// File: rtl/bcd_mac_x10.sv
// One BCD-to-binary step: sum = acc*10 + digit using shifts and adds only.
// digit_err flags a nibble above 9; the raw nibble value is still accumulated.
module bcd_mac_x10
    import number_io_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [ACC_W-1:0]   sum,
    output logic               digit_err
);

    assign sum       = (acc << 3) + (acc << 1) + ACC_W'(digit);
    assign digit_err = (digit > DIGIT_W'(9));

endmodule

// File: rtl/number_mmio_controller.sv
// Sequences the number-input buffer: captures a completed BCD entry, converts it to
// binary one digit per cycle, exposes it over MMIO and acknowledges the buffer.
module number_mmio_controller
    import number_io_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
    input  logic                          number_valid,
    output logic                          buf_ack,
    input  logic                          bus_re,
    input  logic                          bus_we,
    input  logic [3:0]                    bus_addr,
    input  logic [BUS_W-1:0]              bus_wdata,
    output logic [BUS_W-1:0]              bus_rdata
);

    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int ACC_W = BUS_W;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t               state_reg, state_next;
    logic [BCD_W-1:0]     raw_reg;
    logic [ACC_W-1:0]     acc_reg;
    logic [ACC_W-1:0]     value_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 err_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 buf_ack_reg, buf_ack_next;
    logic [BUS_W-1:0]     bus_rdata_reg;
    logic [BUS_W-1:0]     rdata_mux;

    logic                 value_read;
    logic                 discard_wr;
    logic                 count_inc;
    logic                 conv_step;
    logic                 ld_value;
    logic [DIGIT_W-1:0]   cur_digit;
    logic [ACC_W-1:0]     mac_sum;
    logic                 mac_err;
    logic                 wdata_unused;

    assign value_read   = bus_re && (bus_addr == OFF_VALUE);
    assign discard_wr   = bus_we && (bus_addr == OFF_STATUS) && bus_wdata[0];
    assign wdata_unused = ^bus_wdata[BUS_W-1:1];

    // Digit lanes of the captured entry, selected most-significant first by idx_reg.
    logic [DIGIT_W-1:0] digits [NUM_DIGITS];
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digits[gi] = raw_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate
    assign cur_digit = digits[idx_reg];

    bcd_mac_x10 #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc       (acc_reg),
        .digit     (cur_digit),
        .sum       (mac_sum),
        .digit_err (mac_err)
    );

    always_comb begin
        state_next   = state_reg;
        buf_ack_next = 1'b0;
        count_inc    = 1'b0;
        conv_step    = 1'b0;
        ld_value     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (number_valid) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (discard_wr) begin
                    state_next   = S_WAIT_CLR;
                    buf_ack_next = 1'b1;
                end else begin
                    state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (discard_wr) begin
                    state_next   = S_WAIT_CLR;
                    buf_ack_next = 1'b1;
                end else begin
                    conv_step = 1'b1;
                    if (idx_reg == '0) begin
                        state_next = S_READY;
                        ld_value   = 1'b1;
                    end
                end
            end
            S_READY: begin
                // A VALUE read takes priority over a discard in the same cycle.
                if (value_read) begin
                    state_next   = S_WAIT_CLR;
                    buf_ack_next = 1'b1;
                    count_inc    = 1'b1;
                end else if (discard_wr) begin
                    state_next   = S_WAIT_CLR;
                    buf_ack_next = 1'b1;
                end
            end
            S_WAIT_CLR: begin
                if (!number_valid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_mux = '0;
        case (bus_addr)
            OFF_VALUE:  rdata_mux = value_reg;
            OFF_STATUS: begin
                rdata_mux[ST_READY]   = (state_reg == S_READY);
                rdata_mux[ST_PENDING] = number_valid;
                rdata_mux[ST_BUSY]    = (state_reg == S_CAPTURE) || (state_reg == S_CONVERT);
                rdata_mux[ST_ERR]     = err_reg;
            end
            OFF_RAW:    rdata_mux = BUS_W'(raw_reg);
            OFF_COUNT:  rdata_mux = BUS_W'(count_reg);
            default:    rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            raw_reg       <= '0;
            acc_reg       <= '0;
            value_reg     <= '0;
            idx_reg       <= '0;
            err_reg       <= 1'b0;
            count_reg     <= '0;
            buf_ack_reg   <= 1'b0;
            bus_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            buf_ack_reg <= buf_ack_next;
            // The buffer output is registered, so bcd_in is stable one cycle after valid.
            if (state_reg == S_CAPTURE) begin
                raw_reg <= bcd_in;
                acc_reg <= '0;
                idx_reg <= IDX_W'(NUM_DIGITS - 1);
                err_reg <= 1'b0;
            end
            if (conv_step) begin
                acc_reg <= mac_sum;
                idx_reg <= idx_reg - IDX_W'(1);
                if (mac_err) err_reg <= 1'b1;
            end
            if (ld_value)  value_reg <= mac_sum;
            if (count_inc) count_reg <= count_reg + CNT_W'(1);
            if (bus_re)    bus_rdata_reg <= rdata_mux;
        end
    end

    assign buf_ack   = buf_ack_reg;
    assign bus_rdata = bus_rdata_reg;

endmodule

// File: tb/tb_number_mmio_controller.sv
// Scoreboard bench for number_mmio_controller: entries are pushed with their expected
// conversion when driven and popped when the controller reports READY.
module tb_number_mmio_controller;
    import number_io_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bcd_in = '0;
    logic        number_valid = 1'b0;
    logic        buf_ack;
    logic        bus_re = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] bcd;
        logic [31:0] value;
        logic        err;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] count_model = '0;

    number_mmio_controller #(
        .NUM_DIGITS (8),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bcd_in       (bcd_in),
        .number_valid (number_valid),
        .buf_ack      (buf_ack),
        .bus_re       (bus_re),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_read(input logic [3:0] addr, output logic [31:0] data);
        bus_re   = 1'b1;
        bus_addr = addr;
        tick();
        bus_re = 1'b0;
        data   = bus_rdata;
    endtask

    task automatic mmio_write(input logic [3:0] addr, input logic [31:0] wdata);
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = wdata;
        tick();
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    // Reference conversion using ordinary multiplication.
    function automatic exp_t model(input logic [31:0] bcd);
        exp_t e;
        logic [3:0] d;
        e.bcd   = bcd;
        e.value = '0;
        e.err   = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            d       = bcd[i*4 +: 4];
            e.value = e.value * 10 + 32'(d);
            if (d > 4'd9) e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic start_entry(input logic [31:0] bcd, input bit push);
        bcd_in       = bcd;
        number_valid = 1'b1;
        if (push) exp_q.push_back(model(bcd));
    endtask

    task automatic wait_ready();
        logic [31:0] d;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            mmio_read(OFF_STATUS, d);
            seen = d[ST_READY];
        end
        if (!seen) check_eq("ready_timeout", 32'(seen), 32'd1);
    endtask

    task automatic complete_entry();
        exp_t e;
        logic [31:0] d;
        check_eq("sb_size", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        mmio_read(OFF_RAW, d);
        check_eq("raw", d, e.bcd);
        mmio_read(OFF_STATUS, d);
        check_eq("status_ready", d, {28'b0, e.err, 1'b0, 1'b1, 1'b1});
        mmio_read(OFF_VALUE, d);
        check_eq("value", d, e.value);
        check_eq("ack_on_read", 32'(buf_ack), 32'd1);
        count_model++;
        number_valid = 1'b0;
        tick();
        check_eq("ack_single", 32'(buf_ack), 32'd0);
        mmio_read(OFF_STATUS, d);
        check_eq("status_idle", d, {28'b0, e.err, 3'b000});
        mmio_read(OFF_VALUE, d);
        check_eq("value_reread", d, e.value);
        check_eq("no_ack_reread", 32'(buf_ack), 32'd0);
        mmio_read(OFF_COUNT, d);
        check_eq("count", d, 32'(count_model));
        $display("txn bcd=%08h value=%08h err=%0d count=%0d", e.bcd, e.value, e.err, count_model);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] exp_st;
        logic [31:0] rnd;

        tick();
        tick();
        check_eq("reset_rdata", bus_rdata, 32'd0);
        check_eq("reset_ack", 32'(buf_ack), 32'd0);
        rst_n = 1'b1;
        tick();
        mmio_read(OFF_STATUS, d);
        check_eq("reset_status", d, 32'd0);
        mmio_read(OFF_VALUE, d);
        check_eq("reset_value", d, 32'd0);
        mmio_read(OFF_COUNT, d);
        check_eq("reset_count", d, 32'd0);

        // Cycle-accurate STATUS trace: valid rises just after edge N, READY after edge N+10.
        start_entry(32'h0001_2345, 1'b1);
        bus_re   = 1'b1;
        bus_addr = OFF_STATUS;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1)       exp_st = 32'h2;
            else if (k <= 10) exp_st = 32'h6;
            else              exp_st = 32'h3;
            check_eq($sformatf("status_trace_%0d", k), bus_rdata, exp_st);
        end
        bus_re = 1'b0;
        complete_entry();

        start_entry(32'h9999_9999, 1'b1);
        wait_ready();
        complete_entry();

        start_entry(32'h0000_001A, 1'b1);
        wait_ready();
        complete_entry();

        start_entry(32'h0000_0042, 1'b1);
        wait_ready();
        mmio_write(OFF_VALUE, 32'h1);
        check_eq("wr_value_no_ack", 32'(buf_ack), 32'd0);
        mmio_write(OFF_COUNT, 32'hFF);
        check_eq("wr_count_no_ack", 32'(buf_ack), 32'd0);
        complete_entry();

        // Discard write in IDLE is ignored.
        mmio_write(OFF_STATUS, 32'h1);
        check_eq("discard_idle_ack", 32'(buf_ack), 32'd0);
        mmio_read(OFF_STATUS, d);
        check_eq("discard_idle_status", d, 32'd0);

        // Discard mid-conversion.
        start_entry(32'h0000_0777, 1'b0);
        repeat (4) tick();
        mmio_write(OFF_STATUS, 32'h1);
        check_eq("discard_ack", 32'(buf_ack), 32'd1);
        number_valid = 1'b0;
        tick();
        check_eq("discard_ack_single", 32'(buf_ack), 32'd0);
        mmio_read(OFF_VALUE, d);
        check_eq("discard_value_kept", d, 32'd42);
        check_eq("discard_no_ack", 32'(buf_ack), 32'd0);
        mmio_read(OFF_COUNT, d);
        check_eq("discard_count_kept", d, 32'(count_model));
        $display("txn discard bcd=00000777 count=%0d", count_model);

        // Asynchronous reset mid-conversion with the entry still pending.
        start_entry(32'h0000_0305, 1'b1);
        repeat (4) tick();
        mmio_read(OFF_VALUE, d);
        check_eq("value_busy_read", d, 32'd42);
        check_eq("value_busy_no_ack", 32'(buf_ack), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rdata", bus_rdata, 32'd0);
        check_eq("async_ack", 32'(buf_ack), 32'd0);
        count_model = '0;
        tick();
        tick();
        rst_n = 1'b1;
        mmio_read(OFF_COUNT, d);
        check_eq("post_reset_count", d, 32'd0);
        wait_ready();
        complete_entry();

        // 256 random clean entries carry COUNT through its wrap.
        for (int n = 0; n < 256; n++) begin
            rnd = '0;
            for (int i = 0; i < 8; i++) rnd[i*4 +: 4] = 4'($urandom_range(0, 9));
            start_entry(rnd, 1'b1);
            wait_ready();
            complete_entry();
        end
        mmio_read(OFF_COUNT, d);
        check_eq("count_wrapped", d, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
